alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_pkg.sv | 42 ++++
 rtl/alu_issue_decode.sv | 48 ++++
 rtl/alu_issue_ctrl.sv | 79 +++++++
 tb/tb_alu_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared ALU control codes, MIPS opcode/funct constants, FSM state type
package alu_issue_pkg;
  localparam logic [3:0] CTRL_NONE = 4'd0;
  localparam logic [3:0] CTRL_ADD  = 4'd1;
  localparam logic [3:0] CTRL_SUB  = 4'd2;
  localparam logic [3:0] CTRL_SLL  = 4'd3;
  localparam logic [3:0] CTRL_SRL  = 4'd4;
  localparam logic [3:0] CTRL_AND  = 4'd5;
  localparam logic [3:0] CTRL_OR   = 4'd6;
  localparam logic [3:0] CTRL_NOR  = 4'd7;
  localparam logic [3:0] CTRL_SLTU = 4'd8;
  localparam logic [3:0] CTRL_SLT  = 4'd9;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  function automatic logic [3:0] funct_ctrl(input logic [5:0] f);
    case (f)
      FN_ADD:  return CTRL_ADD;
      FN_SUB:  return CTRL_SUB;
      FN_SLL:  return CTRL_SLL;
      FN_SRL:  return CTRL_SRL;
      FN_AND:  return CTRL_AND;
      FN_OR:   return CTRL_OR;
      FN_NOR:  return CTRL_NOR;
      FN_SLTU: return CTRL_SLTU;
      FN_SLT:  return CTRL_SLT;
      default: return CTRL_NONE;
    endcase
  endfunction
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational MIPS decode into ALU control and operands
// Ports: instr/rs_data/rt_data in; ctrl, in1, in2, shamt, illegal out.
// ALU_ISSUE_IMM_EN adds ADDI/ANDI/ORI; otherwise those opcodes decode as illegal.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [3:0]  ctrl,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  shamt,
  output logic        illegal
);
  logic [5:0] opcode;
  logic [15:0] imm;
  logic unused_bits;
  assign opcode = instr[31:26];
  assign imm = instr[15:0];
  assign unused_bits = ^instr;
  always_comb begin
    ctrl = CTRL_NONE;
    in1 = rs_data;
    in2 = rt_data;
    shamt = instr[10:6];
    case (opcode)
      OP_RTYPE: ctrl = funct_ctrl(instr[5:0]);
      OP_BEQ:   ctrl = CTRL_SUB;
`ifdef ALU_ISSUE_IMM_EN
      OP_ADDI: begin
        ctrl = CTRL_ADD;
        in2 = {{16{imm[15]}}, imm};
      end
      OP_ANDI: begin
        ctrl = CTRL_AND;
        in2 = {16'h0, imm};
      end
      OP_ORI: begin
        ctrl = CTRL_OR;
        in2 = {16'h0, imm};
      end
`endif
      default: ctrl = CTRL_NONE;
    endcase
    illegal = ctrl == CTRL_NONE;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready front end that decodes an instruction, issues it to an external combinational ALU and returns the result
// Ports: clk, rst (async active-high); in_valid/in_ready with instr, rs_data, rt_data;
// registered alu_in1/alu_in2/alu_shamt/alu_ctrl out, alu_result/alu_zero back;
// out_valid/out_ready with out_result, out_zero, out_illegal.
// ALU_ISSUE_IMM_EN enables immediate-form decode in alu_issue_decode.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_illegal
);
  state_t state, state_nx;
  logic accept, deliver, ill_q, d_ill;
  logic [3:0] d_ctrl;
  logic [31:0] d_in1, d_in2;
  logic [4:0] d_shamt;
  alu_issue_decode u_dec (
    .instr(instr),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .ctrl(d_ctrl),
    .in1(d_in1),
    .in2(d_in2),
    .shamt(d_shamt),
    .illegal(d_ill)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // out_valid is only raised one cycle into RESP, so the handshake must be gated on it
  always_comb begin
    deliver = state == RESP && out_valid && out_ready;
    in_ready = state == IDLE || deliver;
    accept = in_valid && in_ready;
    state_nx = state == ISSUE ? RESP : accept ? ISSUE : (state == RESP && !deliver) ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_shamt <= '0;
      alu_ctrl <= CTRL_NONE;
      ill_q <= 1'b0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_illegal <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        alu_in1 <= d_in1;
        alu_in2 <= d_in2;
        alu_shamt <= d_shamt;
        alu_ctrl <= d_ctrl;
        ill_q <= d_ill;
      end
      if (state == ISSUE) begin
        out_result <= ill_q ? '0 : alu_result;
        out_zero <= !ill_q && alu_zero;
        out_illegal <= ill_q;
      end
      out_valid <= state == RESP && !deliver;
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: self-checking bench with a behavioural ALU and an instruction-level reference model
module tb_alu_issue_ctrl;
  logic clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, out_zero, out_illegal, alu_zero;
  logic [31:0] instr, rs_data, rt_data, alu_in1, alu_in2, alu_result, out_result;
  logic [4:0] alu_shamt;
  logic [3:0] alu_ctrl;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal)
  );

  // external ALU; code 0 returns junk so an illegal op that is not masked shows up
  always_comb begin
    alu_result = 32'hDEADBEEF;
    case (alu_ctrl)
      4'd1: alu_result = alu_in1 + alu_in2;
      4'd2: alu_result = alu_in1 - alu_in2;
      4'd3: alu_result = alu_in2 << alu_shamt;
      4'd4: alu_result = alu_in2 >> alu_shamt;
      4'd5: alu_result = alu_in1 & alu_in2;
      4'd6: alu_result = alu_in1 | alu_in2;
      4'd7: alu_result = ~(alu_in1 | alu_in2);
      4'd8: alu_result = {31'b0, alu_in1 < alu_in2};
      4'd9: alu_result = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = alu_ctrl == 4'd0 || alu_result == 32'h0;
  end

  typedef struct {
    string nm;
    logic [31:0] instr, rs, rt, in2, res;
    logic [3:0] ctrl;
    logic zero, ill;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] r_i(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'd3, 5'd4, 5'd5, sh, fn};
  endfunction

  function automatic logic [31:0] i_i(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd3, 5'd4, imm};
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] ins, rs, rt, in2, res,
                              input logic [3:0] ctrl, input logic zero, ill);
    vec_t v;
    v.nm = nm; v.instr = ins; v.rs = rs; v.rt = rt; v.in2 = in2; v.res = res;
    v.ctrl = ctrl; v.zero = zero; v.ill = ill;
    return v;
  endfunction

  // instruction semantics straight from the MIPS definitions
  function automatic void ref_model(input logic [31:0] ins, rs, rt, output logic [3:0] ctrl,
                                    output logic [31:0] in2, res, output logic zero, ill);
    logic [5:0] op, fn;
    logic [4:0] sh;
    logic [15:0] imm;
    op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6]; imm = ins[15:0];
    ctrl = 4'd0; in2 = rt; res = 32'h0;
    if (op == 6'h00) begin
      if (fn == 6'h20) begin ctrl = 4'd1; res = rs + rt; end
      if (fn == 6'h22) begin ctrl = 4'd2; res = rs - rt; end
      if (fn == 6'h00) begin ctrl = 4'd3; res = rt * (32'd1 << sh); end
      if (fn == 6'h02) begin ctrl = 4'd4; res = rt / (32'd1 << sh); end
      if (fn == 6'h24) begin ctrl = 4'd5; res = rs & rt; end
      if (fn == 6'h25) begin ctrl = 4'd6; res = rs | rt; end
      if (fn == 6'h27) begin ctrl = 4'd7; res = ~(rs | rt); end
      if (fn == 6'h2B) begin ctrl = 4'd8; res = (rs < rt) ? 32'd1 : 32'd0; end
      if (fn == 6'h2A) begin ctrl = 4'd9; res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
    end
    if (op == 6'h04) begin ctrl = 4'd2; res = rs - rt; end
`ifdef ALU_ISSUE_IMM_EN
    if (op == 6'h08) begin ctrl = 4'd1; in2 = {{16{imm[15]}}, imm}; res = rs + in2; end
    if (op == 6'h0C) begin ctrl = 4'd5; in2 = {16'h0, imm}; res = rs & in2; end
    if (op == 6'h0D) begin ctrl = 4'd6; in2 = {16'h0, imm}; res = rs | in2; end
`endif
    ill = ctrl == 4'd0;
    zero = !ill && res == 32'h0;
  endfunction

  task automatic run_txn(input vec_t v, input int stall);
    @(negedge clk);
    chk({v.nm, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; instr = v.instr; rs_data = v.rs; rt_data = v.rt;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk({v.nm, " in_ready issue"}, 32'(in_ready), 32'd0);
    chk({v.nm, " out_valid T+1"}, 32'(out_valid), 32'd0);
    chk({v.nm, " alu_ctrl"}, 32'(alu_ctrl), 32'(v.ctrl));
    chk({v.nm, " alu_in1"}, alu_in1, v.rs);
    chk({v.nm, " alu_in2"}, alu_in2, v.in2);
    chk({v.nm, " alu_shamt"}, 32'(alu_shamt), 32'(v.instr[10:6]));
    @(negedge clk);
    chk({v.nm, " out_valid T+2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({v.nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({v.nm, " out_result"}, out_result, v.res);
    chk({v.nm, " out_zero"}, 32'(out_zero), 32'(v.zero));
    chk({v.nm, " out_illegal"}, 32'(out_illegal), 32'(v.ill));
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      chk({v.nm, " stall valid"}, 32'(out_valid), 32'd1);
      chk({v.nm, " stall result"}, out_result, v.res);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.nm, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t tv[$];
    vec_t v;
    logic [5:0] fn_pool [10];
    logic [5:0] op_pool [6];
    logic [31:0] w;
    fn_pool = '{6'h20, 6'h22, 6'h00, 6'h02, 6'h24, 6'h25, 6'h27, 6'h2B, 6'h2A, 6'h3F};
    op_pool = '{6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h3F};

    tv.push_back(mk("add", r_i(6'h20, 5'd0), 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 4'd1, 1'b1, 1'b0));
    tv.push_back(mk("sub", r_i(6'h22, 5'd0), 32'hFFFFFFFF, 32'h1, 32'h1, 32'hFFFFFFFE, 4'd2, 1'b0, 1'b0));
    tv.push_back(mk("sll", r_i(6'h00, 5'd3), 32'h1234, 32'h5, 32'h5, 32'h28, 4'd3, 1'b0, 1'b0));
    tv.push_back(mk("srl", r_i(6'h02, 5'd2), 32'h1234, 32'h5, 32'h5, 32'h1, 4'd4, 1'b0, 1'b0));
    tv.push_back(mk("slt", r_i(6'h2A, 5'd0), 32'hFFFFFFFE, 32'h1, 32'h1, 32'h1, 4'd9, 1'b0, 1'b0));
    tv.push_back(mk("sltu", r_i(6'h2B, 5'd0), 32'hFFFFFFFE, 32'h1, 32'h1, 32'h0, 4'd8, 1'b1, 1'b0));
    tv.push_back(mk("nor", r_i(6'h27, 5'd0), 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 4'd7, 1'b1, 1'b0));
    tv.push_back(mk("and", r_i(6'h24, 5'd0), 32'hF0F0, 32'hFF00, 32'hFF00, 32'hF000, 4'd5, 1'b0, 1'b0));
    tv.push_back(mk("or", r_i(6'h25, 5'd0), 32'hF0F0, 32'hFF00, 32'hFF00, 32'hFFF0, 4'd6, 1'b0, 1'b0));
    tv.push_back(mk("fn3f", r_i(6'h3F, 5'd0), 32'h5, 32'h5, 32'h5, 32'h0, 4'd0, 1'b0, 1'b1));
    tv.push_back(mk("beq", i_i(6'h04, 16'h0010), 32'h7, 32'h7, 32'h7, 32'h0, 4'd2, 1'b1, 1'b0));
    tv.push_back(mk("lw", i_i(6'h23, 16'h0004), 32'h7, 32'h9, 32'h9, 32'h0, 4'd0, 1'b0, 1'b1));
`ifdef ALU_ISSUE_IMM_EN
    tv.push_back(mk("addi", i_i(6'h08, 16'hFFFF), 32'h1, 32'h9, 32'hFFFFFFFF, 32'h0, 4'd1, 1'b1, 1'b0));
    tv.push_back(mk("andi", i_i(6'h0C, 16'h8001), 32'hFFFF0003, 32'h9, 32'h8001, 32'h1, 4'd5, 1'b0, 1'b0));
    tv.push_back(mk("ori", i_i(6'h0D, 16'h8000), 32'h1, 32'h9, 32'h8000, 32'h8001, 4'd6, 1'b0, 1'b0));
`else
    tv.push_back(mk("addi", i_i(6'h08, 16'hFFFF), 32'h1, 32'h9, 32'h9, 32'h0, 4'd0, 1'b0, 1'b1));
    tv.push_back(mk("andi", i_i(6'h0C, 16'h8001), 32'hFFFF0003, 32'h9, 32'h9, 32'h0, 4'd0, 1'b0, 1'b1));
    tv.push_back(mk("ori", i_i(6'h0D, 16'h8000), 32'h1, 32'h9, 32'h9, 32'h0, 4'd0, 1'b0, 1'b1));
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_flags", {30'b0, out_zero, out_illegal}, 32'd0);
    chk("rst alu_ops", alu_in1 | alu_in2, 32'd0);
    chk("rst alu_ctl", {23'b0, alu_shamt, alu_ctrl}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel in_ready", 32'(in_ready), 32'd1);
    chk("rel out_valid", 32'(out_valid), 32'd0);

    foreach (tv[i]) run_txn(tv[i], i % 3);

    // long stall, then release with a new request already waiting
    @(negedge clk);
    in_valid = 1'b1; instr = r_i(6'h20, 5'd0); rs_data = 32'd3; rt_data = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold valid0", 32'(out_valid), 32'd1);
    chk("hold result0", out_result, 32'd7);
    in_valid = 1'b1; instr = r_i(6'h25, 5'd0); rs_data = 32'hF0; rt_data = 32'h0F;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("hold valid", 32'(out_valid), 32'd1);
      chk("hold result", out_result, 32'd7);
      chk("hold alu_ctrl", 32'(alu_ctrl), 32'd1);
      chk("hold alu_in1", alu_in1, 32'd3);
      chk("hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b out_valid", 32'(out_valid), 32'd0);
    chk("b2b in_ready", 32'(in_ready), 32'd0);
    chk("b2b alu_ctrl", 32'(alu_ctrl), 32'd6);
    chk("b2b alu_in1", alu_in1, 32'hF0);
    @(negedge clk);
    chk("b2b valid T+2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("b2b valid", 32'(out_valid), 32'd1);
    chk("b2b result", out_result, 32'hFF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b done", 32'(out_valid), 32'd0);

    // reset while the request sits in ISSUE
    @(negedge clk);
    in_valid = 1'b1; instr = r_i(6'h20, 5'd0); rs_data = 32'd5; rt_data = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid in_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("mid out_valid", 32'(out_valid), 32'd0);
    chk("mid out_result", out_result, 32'd0);
    chk("mid out_flags", {30'b0, out_zero, out_illegal}, 32'd0);
    chk("mid alu_ops", alu_in1 | alu_in2, 32'd0);
    chk("mid alu_ctl", {23'b0, alu_shamt, alu_ctrl}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("post rst valid", 32'(out_valid), 32'd0);
      chk("post rst ready", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        w[31:26] = 6'h00;
        w[5:0] = fn_pool[$urandom_range(0, 9)];
      end else w[31:26] = op_pool[$urandom_range(0, 5)];
      v.nm = "rand";
      v.instr = w;
      v.rs = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
      v.rt = ($urandom_range(0, 3) == 0) ? v.rs : $urandom;
      ref_model(v.instr, v.rs, v.rt, v.ctrl, v.in2, v.res, v.zero, v.ill);
      run_txn(v, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
